// File: rtl/irq_ctrl_v1.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_v1
// Purpose  : SFR-mapped interrupt controller that latches edges, masks them and
//            arbitrates them. Requests go to the CPU with a req/ack handshake
//            and end with an EOI write.
// Option   : IRQ_CTRL_ROUND_ROBIN_EN selects round-robin arbitration
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl_v1 #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFF864,
    parameter int          N_SRC      = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    input  logic                  sys_wr_en,
    input  logic [DATA_WIDTH-1:0] sys_sw_value,
    input  logic [N_SRC-1:0]      irq_src,
    input  logic                  irq_ack,
    output logic [DATA_WIDTH-1:0] sfr_rd_dout,
    output logic                  irq_req,
    output logic [4:0]            irq_id
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_EN   = ADDR_WIDTH'(BASE_ADDR + 32'h4);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_PEND = ADDR_WIDTH'(BASE_ADDR + 32'h8);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STAT = ADDR_WIDTH'(BASE_ADDR + 32'hC);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_EOI  = ADDR_WIDTH'(BASE_ADDR + 32'h10);

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    localparam logic c_RR = 1'b1;
`else
    localparam logic c_RR = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t             state_q;
    logic               irq_req_q;
    logic [4:0]         irq_id_q;
    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   pend_q;
    logic [N_SRC-1:0]   pend_d;
    logic [N_SRC-1:0]   en_q;
    logic               gie_q;
    logic               eoi_err_q;

    logic               w_wr_ctrl;
    logic               w_wr_en;
    logic               w_wr_pend;
    logic               w_wr_eoi;
    logic [N_SRC-1:0]   w_edge;
    logic [N_SRC-1:0]   w_elig;
    logic [N_SRC-1:0]   w_cur_onehot;
    logic [N_SRC-1:0]   w_w1c_mask;
    logic [N_SRC-1:0]   w_ack_mask;
    logic               w_any_elig;
    logic               w_cur_elig;
    logic               w_ack_take;
    logic               w_eoi_match;
    logic               w_eoi_bad;
    logic [4:0]         w_win_id;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic               w_unused_sw;

    assign w_wr_ctrl = sys_wr_en && (sys_addr == c_ADDR_CTRL);
    assign w_wr_en   = sys_wr_en && (sys_addr == c_ADDR_EN);
    assign w_wr_pend = sys_wr_en && (sys_addr == c_ADDR_PEND);
    assign w_wr_eoi  = sys_wr_en && (sys_addr == c_ADDR_EOI);

    assign w_edge     = irq_src & ~src_q;
    assign w_elig     = pend_q & en_q & {N_SRC{gie_q}};
    assign w_any_elig = |w_elig;
    assign w_cur_elig = |(w_elig & w_cur_onehot);
    assign w_ack_take = (state_q == ST_REQ) && irq_ack;

    assign w_eoi_match = w_wr_eoi && (state_q == ST_SVC) && (sys_sw_value[4:0] == irq_id_q);
    assign w_eoi_bad   = w_wr_eoi && !w_eoi_match;

    assign w_unused_sw = &{1'b0, sys_sw_value};

    always_comb begin
        w_cur_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_cur_onehot[i] = (irq_id_q == 5'(i));
        end
    end

    // A fresh edge beats both the W1C clear and the ack clear of the same bit.
    always_comb begin
        w_w1c_mask = '0;
        w_ack_mask = '0;
        if (w_wr_pend) begin
            w_w1c_mask = sys_sw_value[N_SRC-1:0];
        end
        if (w_ack_take) begin
            w_ack_mask = w_cur_onehot;
        end
        pend_d = (pend_q & ~w1c_mask_or_ack(w_w1c_mask, w_ack_mask)) | w_edge;
    end

    function automatic logic [N_SRC-1:0] w1c_mask_or_ack(input logic [N_SRC-1:0] a,
                                                         input logic [N_SRC-1:0] b);
        return a | b;
    endfunction

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [4:0] ptr_q;
    int         w_dist;
    int         w_best;

    // Winner is the eligible source with the smallest forward distance from ptr_q.
    always_comb begin
        w_win_id = '0;
        w_best   = N_SRC;
        w_dist   = 0;
        for (int i = 0; i < N_SRC; i++) begin
            w_dist = i - int'(ptr_q);
            if (w_dist < 0) begin
                w_dist = w_dist + N_SRC;
            end
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_win_id = 5'(i);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ptr_q <= '0;
        end else if (w_ack_take) begin
            ptr_q <= (irq_id_q == 5'(N_SRC - 1)) ? 5'd0 : irq_id_q + 5'd1;
        end
    end
`else
    always_comb begin
        w_win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_id = 5'(i);
            end
        end
    end
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            src_q     <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            gie_q     <= 1'b0;
            eoi_err_q <= 1'b0;
        end else begin
            src_q  <= irq_src;
            pend_q <= pend_d;
            if (w_wr_en) begin
                en_q <= sys_sw_value[N_SRC-1:0];
            end
            if (w_wr_ctrl) begin
                gie_q <= sys_sw_value[0];
                if (sys_sw_value[1]) begin
                    eoi_err_q <= 1'b0;
                end
            end
            if (w_eoi_bad) begin
                eoi_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        state_q   <= ST_REQ;
                        irq_req_q <= 1'b1;
                        irq_id_q  <= w_win_id;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state_q   <= ST_SVC;
                        irq_req_q <= 1'b0;
                    end else if (!w_cur_elig) begin
                        state_q   <= ST_IDLE;
                        irq_req_q <= 1'b0;
                        irq_id_q  <= '0;
                    end
                end
                ST_SVC: begin
                    if (w_eoi_match) begin
                        state_q  <= ST_IDLE;
                        irq_id_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    irq_req_q <= 1'b0;
                    irq_id_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (sys_addr == c_ADDR_CTRL) begin
            w_rd_data[0] = gie_q;
            w_rd_data[1] = eoi_err_q;
            w_rd_data[2] = c_RR;
        end else if (sys_addr == c_ADDR_EN) begin
            w_rd_data[N_SRC-1:0] = en_q;
        end else if (sys_addr == c_ADDR_PEND) begin
            w_rd_data[N_SRC-1:0] = pend_q;
        end else if (sys_addr == c_ADDR_STAT) begin
            w_rd_data[4:0] = irq_id_q;
            w_rd_data[8]   = (state_q == ST_SVC);
            w_rd_data[9]   = irq_req_q;
        end
    end

    assign sfr_rd_dout = w_rd_data;
    assign irq_req     = irq_req_q;
    assign irq_id      = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_v1.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl_v1
// Purpose  : Directed and randomized bench for irq_ctrl_v1 with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl_v1;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'hFFFFF864;
    localparam logic [31:0] NMASK = 32'h0000FFFF;
    localparam logic [31:0] O_CTRL = 32'h0, O_EN = 32'h4, O_PEND = 32'h8,
                            O_STAT = 32'hC, O_EOI = 32'h10;
    localparam int MI = 0, MR = 1, MS = 2;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          sys_clk;
    logic          sys_rst;
    logic [31:0]   sys_addr;
    logic          sys_wr_en;
    logic [31:0]   sys_sw_value;
    logic [N-1:0]  irq_src;
    logic          irq_ack;
    logic [31:0]   sfr_rd_dout;
    logic          irq_req;
    logic [4:0]    irq_id;

    irq_ctrl_v1 #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .N_SRC      (N)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .sys_addr     (sys_addr),
        .sys_wr_en    (sys_wr_en),
        .sys_sw_value (sys_sw_value),
        .irq_src      (irq_src),
        .irq_ack      (irq_ack),
        .sfr_rd_dout  (sfr_rd_dout),
        .irq_req      (irq_req),
        .irq_id       (irq_id)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, kept as plain numbers and bit vectors.
    bit [31:0] m_pend, m_en, m_src;
    bit        m_gie, m_err, m_req;
    int        m_mode, m_id, m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_src = 0;
        m_gie = 0; m_err = 0; m_req = 0;
        m_mode = MI; m_id = 0; m_ptr = 0;
    endtask

    function automatic int pick(input bit [31:0] elig);
        int start;
        start = RR ? m_ptr : 0;
        for (int k = 0; k < N; k++) begin
            if (elig[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        case (off)
            O_CTRL:  return {29'd0, RR, m_err, m_gie};
            O_EN:    return m_en;
            O_PEND:  return m_pend;
            O_STAT:  return (32'(m_req) << 9) | (32'(m_mode == MS) << 8) | 32'(m_id);
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock from the inputs currently driven, then
    // let the DUT take the same edge and compare its request outputs.
    task automatic step();
        bit [31:0] edges, elig, w1c, ackm, off, val, pend_n, en_n;
        bit        wr, gie_n, err_n, req_n;
        int        mode_n, id_n, ptr_n;
        off   = sys_addr - BASE;
        val   = sys_sw_value;
        wr    = sys_wr_en;
        edges = 32'(irq_src) & ~m_src;
        elig  = m_pend & m_en & (m_gie ? NMASK : 32'h0);
        ackm  = 0;
        mode_n = m_mode; id_n = m_id; req_n = m_req; ptr_n = m_ptr;
        gie_n = m_gie; err_n = m_err; en_n = m_en;
        if (m_mode == MI) begin
            if (elig != 0) begin
                mode_n = MR; req_n = 1; id_n = pick(elig);
            end
        end else if (m_mode == MR) begin
            if (irq_ack) begin
                mode_n = MS; req_n = 0;
                ackm = 32'h1 << m_id;
                ptr_n = (m_id + 1) % N;
            end else if (!elig[m_id]) begin
                mode_n = MI; req_n = 0; id_n = 0;
            end
        end else begin
            if (wr && off == O_EOI && int'(val[4:0]) == m_id) begin
                mode_n = MI; id_n = 0;
            end
        end
        if (wr && off == O_EOI && !(m_mode == MS && int'(val[4:0]) == m_id)) err_n = 1;
        if (wr && off == O_CTRL) begin
            gie_n = val[0];
            if (val[1]) err_n = 0;
        end
        if (wr && off == O_EN) en_n = val & NMASK;
        w1c = (wr && off == O_PEND) ? val : 32'h0;
        pend_n = ((m_pend & ~w1c & ~ackm) | edges) & NMASK;

        m_pend = pend_n; m_en = en_n; m_src = 32'(irq_src);
        m_gie = gie_n; m_err = err_n; m_req = req_n;
        m_mode = mode_n; m_id = id_n; m_ptr = ptr_n;

        @(posedge sys_clk);
        #1;
        check("irq_req", 32'(irq_req), 32'(m_req));
        check("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] val);
        sys_addr = BASE + off;
        sys_wr_en = 1'b1;
        sys_sw_value = val;
        step();
        sys_wr_en = 1'b0;
        sys_sw_value = 32'h0;
        sys_addr = 32'h0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] off);
        sys_wr_en = 1'b0;
        sys_addr = BASE + off;
        #1;
        check(tag, sfr_rd_dout, model_read(BASE + off));
    endtask

    task automatic wait_req();
        for (int k = 0; k < 10 && !irq_req; k++) step();
        check("wait_req", 32'(irq_req), 32'h1);
    endtask

    task automatic serve_one();
        wait_req();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        wr(O_EOI, 32'(m_id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1; sys_addr = 32'h0; sys_wr_en = 1'b0;
        sys_sw_value = 32'h0; irq_src = '0; irq_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_req", 32'(irq_req), 32'h0);
        check("rst_id", 32'(irq_id), 32'h0);
        rd_check("rst_ctrl", O_CTRL);
        rd_check("rst_stat", O_STAT);
        sys_rst = 1'b0;

        // Basic request
        wr(O_CTRL, 32'h1);
        wr(O_EN, 32'h1);
        irq_src = 16'h0001;
        step();
        irq_src = '0;
        rd_check("basic_pend", O_PEND);
        check("basic_pend_val", sfr_rd_dout, 32'h1);
        step();
        check("basic_req", 32'(irq_req), 32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        rd_check("basic_pend_clr", O_PEND);
        rd_check("basic_stat_svc", O_STAT);
        check("basic_stat_val", sfr_rd_dout, 32'h100);
        wr(O_EOI, 32'h0);
        rd_check("basic_stat_idle", O_STAT);
        check("basic_stat_zero", sfr_rd_dout, 32'h0);

        // Fixed priority and EOI-to-next-request latency
        wr(O_EN, 32'hFFFF);
        irq_src = 16'h0024;
        step();
        irq_src = '0;
        step();
        check("prio_id2", 32'(irq_id), 32'd2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        wr(O_EOI, 32'd2);
        check("prio_gap_req", 32'(irq_req), 32'h0);
        step();
        check("prio_id5", 32'(irq_id), 32'd5);
        check("prio_req5", 32'(irq_req), 32'h1);
        serve_one();

        // Arbitration after acking source 2
        irq_src = 16'h0004;
        step();
        irq_src = '0;
        serve_one();
        irq_src = 16'h0022;
        step();
        irq_src = '0;
        step();
        check("arb_after_ack", 32'(irq_id), RR ? 32'd5 : 32'd1);
        serve_one();
        serve_one();

        // Masking and withdrawal
        wr(O_EN, 32'h0);
        irq_src = 16'h0008;
        step();
        irq_src = '0;
        step();
        check("mask_noreq", 32'(irq_req), 32'h0);
        rd_check("mask_pend", O_PEND);
        check("mask_pend_val", sfr_rd_dout, 32'h8);
        wr(O_EN, 32'h8);
        step();
        check("mask_req", 32'(irq_req), 32'h1);
        check("mask_id", 32'(irq_id), 32'd3);
        wr(O_EN, 32'h0);
        step();
        check("withdraw", 32'(irq_req), 32'h0);
        wr(O_PEND, 32'h8);

        // EOI error
        wr(O_EN, 32'h10);
        irq_src = 16'h0010;
        step();
        irq_src = '0;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        wr(O_EOI, 32'd7);
        rd_check("eoi_err_stat", O_STAT);
        check("eoi_err_stat_val", sfr_rd_dout, 32'h104);
        rd_check("eoi_err_ctrl", O_CTRL);
        check("eoi_err_set", sfr_rd_dout, {29'd0, RR, 2'b11});
        wr(O_CTRL, 32'h3);
        rd_check("eoi_err_clr", O_CTRL);
        check("eoi_err_clr_val", sfr_rd_dout, {29'd0, RR, 2'b01});
        wr(O_EOI, 32'd4);
        rd_check("eoi_ok_stat", O_STAT);
        check("eoi_ok_zero", sfr_rd_dout, 32'h0);

        // Set beats W1C on the same bit
        irq_src = 16'h0040;
        step();
        irq_src = '0;
        step();
        sys_addr = BASE + O_PEND; sys_wr_en = 1'b1; sys_sw_value = 32'h40;
        irq_src = 16'h0040;
        step();
        sys_wr_en = 1'b0; sys_sw_value = 32'h0; irq_src = '0;
        rd_check("set_wins", O_PEND);
        check("set_wins_val", sfr_rd_dout, 32'h40);
        wr(O_PEND, 32'h40);

        // Asynchronous reset during service
        wr(O_EN, 32'hFFFF);
        irq_src = 16'h0080;
        step();
        irq_src = '0;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        rd_check("svc_stat", O_STAT);
        check("svc_stat_val", sfr_rd_dout, 32'h107);
        sys_rst = 1'b1;
        #1;
        model_reset();
        check("arst_req", 32'(irq_req), 32'h0);
        rd_check("arst_stat", O_STAT);
        rd_check("arst_en", O_EN);
        check("arst_en_zero", sfr_rd_dout, 32'h0);
        sys_addr = 32'h0;
        #1;
        check("arst_nomatch", sfr_rd_dout, 32'h0);
        sys_rst = 1'b0;

        // Randomized traffic against the reference model
        wr(O_CTRL, 32'h1);
        wr(O_EN, 32'hFFFF);
        for (int it = 0; it < 400; it++) begin
            int r;
            irq_src = N'($urandom & $urandom & $urandom);
            irq_ack = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 11);
            sys_wr_en = (r <= 4);
            case (r)
                0: begin sys_addr = BASE + O_EN;   sys_sw_value = $urandom | $urandom; end
                1: begin sys_addr = BASE + O_PEND; sys_sw_value = $urandom & $urandom; end
                2: begin sys_addr = BASE + O_CTRL;
                         sys_sw_value = {30'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0)}; end
                3: begin sys_addr = BASE + O_EOI;
                         sys_sw_value = ($urandom_range(0, 1) == 1) ? 32'(m_id) : 32'($urandom_range(0, 31)); end
                4: begin sys_addr = BASE + 32'h14; sys_sw_value = $urandom; end
                default: begin sys_addr = BASE + O_STAT; sys_sw_value = $urandom; end
            endcase
            step();
            irq_ack = 1'b0;
            rd_check("rand_rd", 32'(4 * $urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
